inst_fetcher: RTL



---
 rtl/inst_fetcher.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetcher.sv
// Purpose : instruction fetch unit; holds the PC, issues one word fetch at a time to the
//           memory controller and queues returned words (with their PC) for the decoder.
// Latency : request is raised the edge after entering IDLE; a response is visible at the FIFO head
//           on the edge it is accepted; with INST_FETCHER_ICACHE_EN a hit pushes one word per cycle.
// Backpr. : no new fetch is issued while the FIFO would still be full after this edge's pop;
//           rdy_in low freezes every register.
//
// Ports:
//   clk_in, rst (sync, active-high), rdy_in (global freeze when low)
//   if_to_mc_PC / if_to_mc_ready       : fetch address and level-held request to the memory controller
//   mc_to_if_result / mc_to_if_ready   : fetched word and its one-cycle response strobe
//   rob_to_if_jump / rob_to_if_jump_PC : redirect + flush strobe and target
//   if_to_dec_inst / if_to_dec_PC / if_to_dec_valid : FIFO head towards the decoder
//   dec_to_if_ready                    : decoder takes the head this cycle
//
// Build option: define INST_FETCHER_ICACHE_EN for a direct-mapped, one-word-per-line I-cache.
module inst_fetcher #(
    parameter int unsigned QUEUE_DEPTH  = 8,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned ICACHE_LINES = 16
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        rdy_in,
    output logic [31:0] if_to_mc_PC,
    output logic        if_to_mc_ready,
    input  logic [31:0] mc_to_if_result,
    input  logic        mc_to_if_ready,
    input  logic        rob_to_if_jump,
    input  logic [31:0] rob_to_if_jump_PC,
    output logic [31:0] if_to_dec_inst,
    output logic [31:0] if_to_dec_PC,
    output logic        if_to_dec_valid,
    input  logic        dec_to_if_ready
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          req_vld_q, req_vld_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fifo_inst_q [QUEUE_DEPTH];
    logic [31:0]   fifo_pc_q   [QUEUE_DEPTH];

    logic          pop;
    logic          space;
    logic          push;
    logic [31:0]   push_inst;
    logic          hit;
    logic [31:0]   hit_data;

    assign if_to_mc_PC     = req_pc_q;
    assign if_to_mc_ready  = req_vld_q;
    assign if_to_dec_valid = (cnt_q != '0);
    assign if_to_dec_inst  = if_to_dec_valid ? fifo_inst_q[rd_ptr_q] : '0;
    assign if_to_dec_PC    = if_to_dec_valid ? fifo_pc_q[rd_ptr_q]   : '0;

    assign pop   = rdy_in && if_to_dec_valid && dec_to_if_ready;
    // A full FIFO still has room if its head leaves on this same edge.
    assign space = (cnt_q != CW'(QUEUE_DEPTH)) || pop;

    // Next-state / fetch control. A flush never pushes; the PC takes the target last.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        req_vld_d = req_vld_q;
        push      = 1'b0;
        push_inst = mc_to_if_result;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (!rob_to_if_jump && space) begin
                        if (hit) begin
                            push      = 1'b1;
                            push_inst = hit_data;
                            pc_d      = pc_q + 32'd4;
                        end else begin
                            req_pc_d  = pc_q;
                            req_vld_d = 1'b1;
                            state_d   = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mc_to_if_ready) begin
                        req_vld_d = 1'b0;
                        state_d   = IDLE;
                        if (!rob_to_if_jump) begin
                            push = 1'b1;
                            pc_d = pc_q + 32'd4;
                        end
                    end else if (rob_to_if_jump) begin
                        // The controller cannot cancel: keep the old request up and drop its answer.
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (mc_to_if_ready) begin
                        req_vld_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (rob_to_if_jump) begin
                pc_d = rob_to_if_jump_PC;
            end
        end
    end

    // FIFO pointers; pointers wrap naturally because QUEUE_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (rdy_in) begin
            if (rob_to_if_jump) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                cnt_d = cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            req_vld_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            req_vld_q <= req_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst && push) begin
            fifo_inst_q[wr_ptr_q] <= push_inst;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

`ifdef INST_FETCHER_ICACHE_EN
    localparam int unsigned IW = $clog2(ICACHE_LINES);
    localparam int unsigned TW = 32 - IW - 2;

    logic [ICACHE_LINES-1:0] c_vld_q;
    logic [TW-1:0]           c_tag_q  [ICACHE_LINES];
    logic [31:0]             c_data_q [ICACHE_LINES];
    logic [IW-1:0]           rd_idx;
    logic [IW-1:0]           wr_idx;
    logic                    fill;

    assign rd_idx   = pc_q[IW+1:2];
    assign wr_idx   = req_pc_q[IW+1:2];
    assign hit      = c_vld_q[rd_idx] && (c_tag_q[rd_idx] == pc_q[31:IW+2]);
    assign hit_data = c_data_q[rd_idx];
    // Every accepted response fills, dropped ones included: the data is right for req_pc_q.
    assign fill     = rdy_in && mc_to_if_ready && (state_q != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            c_vld_q <= '0;
        end else if (fill) begin
            c_vld_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst && fill) begin
            c_tag_q[wr_idx]  <= req_pc_q[31:IW+2];
            c_data_q[wr_idx] <= mc_to_if_result;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

endmodule
